// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter that shares one SR latch among NREQ requesters.
// Drives timed, mutually exclusive s/r pulses, then reads q back and acknowledges.
module sr_latch_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         op,
  input  logic                    q,
  output logic                    s,
  output logic                    r,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] gnt_id
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, PULSE, RECOVER, DONE} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;
  logic          exp_val;
  logic [7:0]    cnt;

  // Search starts one past the last grant, so a held request is ranked last next time.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s       <= 1'b0;
      r       <= 1'b0;
      ack     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      gnt_id  <= '0;
      last    <= IW'(NREQ - 1);
      exp_val <= 1'b0;
      cnt     <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            exp_val <= op[pick];
            gnt_id  <= pick;
            last    <= pick;
            busy    <= 1'b1;
            // Latch already holds the requested value: acknowledge without pulsing.
            if (q == op[pick]) begin
              state     <= DONE;
              ack[pick] <= 1'b1;
            end else begin
              state <= PULSE;
              s     <= op[pick];
              r     <= ~op[pick];
              cnt   <= 8'(PULSE_CYC - 1);
            end
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            s     <= 1'b0;
            r     <= 1'b0;
            state <= RECOVER;
            cnt   <= 8'(GAP_CYC - 1);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RECOVER: begin
          if (cnt == '0) begin
            state       <= DONE;
            ack[gnt_id] <= 1'b1;
            err         <= (q != exp_val);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Bench for sr_latch_arbiter: behavioural SR latch models, vector table,
// ack scoreboard and hand-written reset/round-robin/parameter-sweep sequences.
module tb_sr_latch_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] op  = '0;
  logic       q;
  logic       s, r, err, busy;
  logic [3:0] ack;
  logic [1:0] gnt_id;

  logic [3:0] req2 = '0;
  logic [3:0] op2  = '0;
  logic       q2   = 1'b1;
  logic       s2, r2, err2, busy2;
  logic [3:0] ack2;
  logic [1:0] gnt_id2;

  logic q_lat = 1'b0, preset_v = 1'b0, preset_tog = 1'b0, seen_tog = 1'b0, stuck = 1'b0;

  typedef struct {int id; logic err;} exp_t;
  typedef struct {
    logic [3:0] req, op;
    logic       q0, stuck, err;
    int         gnt, ns, nr, lat;
  } vec_t;

  exp_t       sb[$];
  logic [3:0] prev_ack = '0;
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  sr_latch_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .q(q),
    .s(s), .r(r), .ack(ack), .err(err), .busy(busy), .gnt_id(gnt_id)
  );

  sr_latch_arbiter #(.NREQ(4), .PULSE_CYC(5), .GAP_CYC(3)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .op(op2), .q(q2),
    .s(s2), .r(r2), .ack(ack2), .err(err2), .busy(busy2), .gnt_id(gnt_id2)
  );

  // Latch model with a preset hook; stuck forces the readback low.
  always @(s or r or preset_tog) begin
    if (preset_tog != seen_tog) begin
      seen_tog = preset_tog;
      q_lat    = preset_v;
    end else if (s) q_lat = 1'b1;
    else if (r)     q_lat = 1'b0;
  end
  assign q = stuck ? 1'b0 : q_lat;

  always @(s2 or r2) begin
    if (s2)      q2 = 1'b1;
    else if (r2) q2 = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    check("s_r_exclusive", {30'd0, s & r, s2 & r2}, 32'd0);
    if (ack != '0) begin
      if (sb.size() == 0) check("unexpected_ack", ack, 32'd0);
      else begin
        e = sb.pop_front();
        check("ack_onehot", ack, 32'd1 << e.id);
        check("ack_err", err, e.err);
        check("ack_gnt_id", gnt_id, e.id);
        check("ack_one_cycle", prev_ack, 32'd0);
      end
    end
    prev_ack = ack;
  endtask

  task automatic run_vec(input vec_t v);
    int w, k, ns, nr;
    stuck      = v.stuck;
    preset_v   = v.q0;
    preset_tog = ~preset_tog;
    req        = v.req;
    op         = v.op;
    sb.push_back('{v.gnt, v.err});
    w = 0;
    do begin tick(); w++; end while (busy !== 1'b1 && w < 10);
    check("grant_edge", w, 1);
    check("grant_id", gnt_id, v.gnt);
    k = 1; ns = 0; nr = 0;
    while (ack == '0 && k < 300) begin
      ns += int'(s);
      nr += int'(r);
      tick();
      k++;
    end
    check("ack_latency", k, v.lat);
    check("s_cycles", ns, v.ns);
    check("r_cycles", nr, v.nr);
    req = '0;
    op  = '0;
    tick();
    check("busy_after_done", busy, 0);
    check("gnt_id_held", gnt_id, v.gnt);
  endtask

  initial begin
    vec_t vt[7];
    int   w, a, k, ns, nr, lastr;
    //          req      op       q0    stuck err   gnt ns nr lat
    vt[0] = '{4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 2, 0, 4};  // single set
    vt[1] = '{4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0, 2, 0, 0, 1};  // skip path
    vt[2] = '{4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1, 2, 0, 4};  // stuck latch
    vt[3] = '{4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 3, 0, 2, 4};  // reset op
    vt[4] = '{4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0, 1, 2, 0, 4};  // two requesters, rr from 0
    vt[5] = '{4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0, 3, 0, 2, 4};  // rr skips 0 after 1
    vt[6] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1};  // pointer wrap, skip reset

    repeat (2) tick();
    check("reset_outputs", {s, r, ack, err, busy, gnt_id}, 0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_after_release", {s, r, ack, err, busy, gnt_id}, 0);

    foreach (vt[i]) run_vec(vt[i]);

    // Reset in the middle of a set pulse: transaction dropped, no ack.
    stuck = 1'b0; preset_v = 1'b0; preset_tog = ~preset_tog;
    req = 4'b0100; op = 4'b0100;
    tick();
    check("pulse_before_reset", {busy, s, r, gnt_id}, {1'b1, 1'b1, 1'b0, 2'd2});
    #2 rst = 1'b1;
    #1 check("async_reset", {s, r, ack, err, busy, gnt_id}, 0);
    req = '0; op = '0;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("quiet_after_reset", {s, r, ack, err, busy, gnt_id}, 0);
    end

    // All four held with alternating set/reset ops.
    stuck = 1'b0; preset_v = 1'b0; preset_tog = ~preset_tog;
    req = 4'b1111; op = 4'b0101;
    for (int t = 0; t < 8; t++) begin
      sb.push_back('{t % 4, 1'b0});
      w = 0;
      do begin tick(); w++; end while (busy !== 1'b1 && w < 10);
      check("rr_grant", gnt_id, t % 4);
      a = 0;
      while (ack == '0 && a < 20) begin tick(); a++; end
      check("rr_latency", a, 3);
      if (t == 7) begin req = '0; op = '0; end
      tick();
      check("rr_idle_gap", busy, 0);
    end

    // Parameter sweep instance: PULSE_CYC=5, GAP_CYC=3, reset request with q=1.
    req2 = 4'b0001; op2 = 4'b0000;
    w = 0;
    do begin tick(); w++; end while (busy2 !== 1'b1 && w < 10);
    check("sweep_grant_edge", w, 1);
    k = 1; ns = 0; nr = 0; lastr = 0;
    while (ack2 == '0 && k < 100) begin
      nr += int'(r2);
      ns += int'(s2);
      if (r2) lastr = k;
      tick();
      k++;
    end
    check("sweep_r_cycles", nr, 5);
    check("sweep_s_cycles", ns, 0);
    check("sweep_ack_latency", k, 9);
    check("sweep_gap", k - lastr - 1, 3);
    check("sweep_ack", ack2, 4'b0001);
    check("sweep_err", err2, 0);
    check("sweep_gnt_id", gnt_id2, 0);
    req2 = '0;
    tick();
    check("sweep_busy_after", busy2, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sr_latch_arbiter.md
Name: sr_latch_arbiter

Overview:
Shares one SR latch (set/reset inputs s, r; output q) among NREQ requesters. Each requester asks for a set or a reset. A round-robin arbiter picks one request at a time. An FSM then drives a timed, mutually exclusive s or r pulse, waits a recovery gap, reads q back and acknowledges. The latch's forbidden S=R=1 input can never be produced. The block sits directly in front of the sr_latch instance.

Parameters:
NREQ, 4, number of requesters (2..8)
PULSE_CYC, 2, cycles s or r is held high (1..255)
GAP_CYC, 1, cycles with s=r=0 after a pulse, before q is checked (1..255)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level
op  input  NREQ  per-requester operation: 1=set, 0=reset; valid while req[i]=1
q  input  1  latch output readback
s  output  1  latch set drive, registered
r  output  1  latch reset drive, registered
ack  output  NREQ  one-cycle completion pulse to the granted requester
err  output  1  one-cycle pulse coincident with ack: q != requested value at check
busy  output  1  high in every state except IDLE
gnt_id  output  $clog2(NREQ)  index of the current/last granted requester

Behaviour:
- Reset (async, immediate): s=0, r=0, ack=0, err=0, busy=0, gnt_id=0, state=IDLE, round-robin pointer last=NREQ-1 (requester 0 has first priority).
- States: IDLE, PULSE, RECOVER, DONE. Every output is registered.
- IDLE: on an edge with any req[i]=1, grant the first requester found at indices last+1, last+2, ... (mod NREQ).
  - Latch its op into exp, set gnt_id=i and last=i.
  - If q==op at that edge: go to DONE with no pulse (skip path).
  - Else: go to PULSE with s=op, r=~op, counter=PULSE_CYC-1.
- PULSE: hold s/r. When counter==0: drive s=r=0, go to RECOVER with counter=GAP_CYC-1. Otherwise decrement.
- RECOVER: s=r=0. When counter==0: go to DONE. At the same edge drive ack[gnt_id]=1 and err=(q!=exp). Otherwise decrement.
- DONE: ack/err are high for exactly this cycle. Next edge returns to IDLE with ack=0, err=0.
  - Result: at least one IDLE cycle between grants.
  - A requester still holding req in IDLE is eligible again, but round-robin ranks it last.
- Skip path: ack pulses in DONE with err=0. s and r stay 0 throughout.
- Latency, pulse path: grant edge E. s/r high in cycles E+1..E+PULSE_CYC. Low for GAP_CYC cycles. ack in cycle E+PULSE_CYC+GAP_CYC+1. Defaults give ack 4 cycles after the grant edge.
- s and r are never 1 simultaneously in any state, including across reset assertion or release.
- Request handshake:
  - Requester holds req[i] and op[i] until it sees ack[i].
  - req or op changes after the grant edge are ignored; the transaction completes and ack still pulses.
  - Dropping req before grant means no grant.
- Simultaneous requests: only one grant per IDLE cycle. Order is strictly round-robin from last+1.
- Pointer wrap: after granting NREQ-1, the search starts at 0.
- Reset mid-operation: s/r deassert immediately. Any in-flight transaction is dropped with no ack; requesters must re-request.
- busy=1 in PULSE, RECOVER and DONE; busy=0 in IDLE.

Test Plan:
- Reset check: assert rst with s=1 in PULSE → s=r=0, ack=0 and busy=0 in the same cycle, before the next clk edge. Release rst with no req → all outputs remain 0.
- Single set: q=0, req=0001, op=0001 (defaults).
  - Grant at edge E; s=1 in cycles E+1 and E+2; r=0 throughout.
  - Model sets q=1 at E+1.
  - ack=0001, err=0 at E+4; busy low from E+5.
- Skip path: q=1, req[2]=1, op[2]=1 → no s/r activity; gnt_id=2; ack=0100 one cycle after the grant edge; err=0.
- Fault: latch model stuck at q=0, set requested by requester 1 → s pulses for 2 cycles; ack=0010 and err=1 in the same cycle.
- Round-robin: req=1111 held, alternating set/reset ops, 8 transactions → grant order 0,1,2,3,0,1,2,3. Every ack is one cycle wide. s&r never 1 (assertion checked every cycle).
- Parameter sweep (PULSE_CYC=5, GAP_CYC=3): reset request → r high exactly 5 cycles, then 3 cycles low, then ack. Total 9 cycles from the grant edge to the ack cycle.
